// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit: redirect selects, FSM encoding and
// the 16-bit adder used for every PC addition.
package pc_fetch_unit_pkg;

  localparam int ADD_W = 16;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_ABS = 2'b01;
  localparam logic [1:0] SEL_REL = 2'b10;
  localparam logic [1:0] SEL_ILL = 2'b11;

  localparam logic [ADD_W-1:0] PC_INC = 16'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Modulo-2^16 add; two's-complement offsets wrap naturally.
  function automatic logic [ADD_W-1:0] add16(input logic [ADD_W-1:0] a,
                                             input logic [ADD_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_target.sv
// Redirect target calculation: sequential, absolute or PC-relative target,
// word-aligned, with illegal-select and misalignment flags. Purely combinational.
module pc_target_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic [AW-1:0] redir_pc_i,
  input  logic [AW-1:0] redir_addr_i,
  input  logic [1:0]    redir_sel_i,
  output logic [AW-1:0] target_o,
  output logic          illegal_o,
  output logic          misaligned_o
);

  logic [AW-1:0] seq_pc;
  logic [AW-1:0] raw_target;

  assign seq_pc = add16(redir_pc_i, PC_INC);

  always_comb begin
    raw_target = seq_pc;
    case (redir_sel_i)
      SEL_SEQ: raw_target = seq_pc;
      SEL_ABS: raw_target = redir_addr_i;
      SEL_REL: raw_target = add16(seq_pc, redir_addr_i);
      default: raw_target = seq_pc;
    endcase
  end

  assign illegal_o    = (redir_sel_i == SEL_ILL);
  assign misaligned_o = !illegal_o && (raw_target[1:0] != 2'b00);
  assign target_o     = {raw_target[AW-1:2], 2'b00};

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register plus single-outstanding imem fetch; data reaches decode the cycle after ack.
// Decode stalls by holding inst_ready low (no new fetch until accepted); redirects override all.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int            AW       = 16,
  parameter int            IW       = 32,
  parameter logic [AW-1:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          inst_valid,
  output logic [IW-1:0] inst_data,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready,
  input  logic          redir_valid,
  input  logic [1:0]    redir_sel,
  input  logic [AW-1:0] redir_pc,
  input  logic [AW-1:0] redir_addr,
  output logic          fetch_err
);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          squash_q, squash_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] data_q, data_d;
  logic [AW-1:0] ipc_q, ipc_d;
  logic          err_q, err_d;

  logic [AW-1:0] target;
  logic          illegal;
  logic          misaligned;
  logic          take_redir;

  pc_target_calc #(.AW(AW)) u_target (
    .redir_pc_i   (redir_pc),
    .redir_addr_i (redir_addr),
    .redir_sel_i  (redir_sel),
    .target_o     (target),
    .illegal_o    (illegal),
    .misaligned_o (misaligned)
  );

  assign take_redir = redir_valid && !illegal;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    squash_d = squash_q;
    valid_d  = valid_q;
    data_d   = data_q;
    ipc_d    = ipc_q;
    err_d    = err_q | (redir_valid & (illegal | misaligned));

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (take_redir) pc_d = target;
      end
      REQ: begin
        if (imem_ack) begin
          if (take_redir) begin
            pc_d     = target;
            squash_d = 1'b0;
          end else if (squash_q) begin
            squash_d = 1'b0;
          end else begin
            data_d  = imem_rdata;
            ipc_d   = addr_q;
            valid_d = 1'b1;
            pc_d    = add16(pc_q, PC_INC);
            state_d = HOLD;
          end
        end else if (take_redir) begin
          pc_d     = target;
          squash_d = 1'b1;
        end
      end
      HOLD: begin
        if (take_redir) begin
          valid_d = 1'b0;
          pc_d    = target;
          state_d = REQ;
        end else if (inst_ready) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // The issued address must not move while a request is still waiting for its ack.
    addr_d = ((state_q == REQ) && !imem_ack) ? addr_q : pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      squash_q <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ipc_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      squash_q <= squash_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ipc_q    <= ipc_d;
      err_q    <= err_d;
    end
  end

  assign imem_req   = (state_q == REQ);
  assign imem_addr  = addr_q;
  assign inst_valid = valid_q;
  assign inst_data  = data_q;
  assign inst_pc    = ipc_q;
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; the bench plays instruction memory.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [15:0] inst_pc;
  logic        inst_ready;
  logic        redir_valid;
  logic [1:0]  redir_sel;
  logic [15:0] redir_pc;
  logic [15:0] redir_addr;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  pc_fetch_unit #(.AW(16), .IW(32), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redir_valid (redir_valid),
    .redir_sel   (redir_sel),
    .redir_pc    (redir_pc),
    .redir_addr  (redir_addr),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [1:0] sel, input logic [15:0] pc, input logic [15:0] addr);
    redir_valid = 1'b1;
    redir_sel   = sel;
    redir_pc    = pc;
    redir_addr  = addr;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b1;
    redir_valid = 1'b0; redir_sel = 2'b00; redir_pc = '0; redir_addr = '0;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h want=0000", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", inst_valid); end
    checks++; if (inst_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h want=0", inst_data); end
    checks++; if (inst_pc !== 16'h0) begin failures++; $display("FAIL reset_pc got=%h want=0", inst_pc); end
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", fetch_err); end
    rst = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b want=1", imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      d = 32'hA000_0000 + 32'(i);
      checks++; if (imem_addr !== 16'(i * 4)) begin failures++; $display("FAIL seq_addr%0d got=%h want=%h", i, imem_addr, 16'(i * 4)); end
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL seq_req%0d got=%b want=1", i, imem_req); end
      step();
      imem_ack = 1'b1; imem_rdata = d;
      step();
      imem_ack = 1'b0;
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL seq_valid%0d got=%b want=1", i, inst_valid); end
      checks++; if (inst_pc !== 16'(i * 4)) begin failures++; $display("FAIL seq_pc%0d got=%h want=%h", i, inst_pc, 16'(i * 4)); end
      checks++; if (inst_data !== d) begin failures++; $display("FAIL seq_data%0d got=%h want=%h", i, inst_data, d); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL seq_hold_req%0d got=%b want=0", i, imem_req); end
      step();
    end
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_000C;
    step();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL bp_valid%0d got=%b want=1", i, inst_valid); end
      checks++; if (inst_data !== 32'hCAFE_000C) begin failures++; $display("FAIL bp_data%0d got=%h want=cafe000c", i, inst_data); end
      checks++; if (inst_pc !== 16'h000C) begin failures++; $display("FAIL bp_pc%0d got=%h want=000c", i, inst_pc); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req%0d got=%b want=0", i, imem_req); end
      step();
    end
    inst_ready = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL bp_resume_req got=%b want=1", imem_req); end
    checks++; if (imem_addr !== 16'h0010) begin failures++; $display("FAIL bp_resume_addr got=%h want=0010", imem_addr); end
  endtask

  task automatic test_redirect_inflight();
    redirect(2'b10, 16'h0010, 16'h0020);
    step();
    redir_valid = 1'b0;
    checks++; if (imem_addr !== 16'h0010) begin failures++; $display("FAIL infl_old_addr got=%h want=0010", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL infl_req_held got=%b want=1", imem_req); end
    step();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL infl_dropped got=%b want=0", inst_valid); end
    checks++; if (imem_addr !== 16'h0034) begin failures++; $display("FAIL infl_new_addr got=%h want=0034", imem_addr); end
    inst_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL infl_target_valid got=%b want=1", inst_valid); end
    checks++; if (inst_pc !== 16'h0034) begin failures++; $display("FAIL infl_target_pc got=%h want=0034", inst_pc); end
  endtask

  task automatic test_redirect_hold();
    inst_ready = 1'b1;
    redirect(2'b01, 16'h0034, 16'h0100);
    step();
    redir_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL hold_dropped got=%b want=0", inst_valid); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL hold_req got=%b want=1", imem_req); end
    checks++; if (imem_addr !== 16'h0100) begin failures++; $display("FAIL hold_addr got=%h want=0100", imem_addr); end
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL hold_err got=%b want=0", fetch_err); end
  endtask

  task automatic test_boundary();
    redirect(2'b01, 16'h0100, 16'hFFFC);
    step();
    redir_valid = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h0;
    step();
    imem_ack = 1'b0;
    checks++; if (imem_addr !== 16'hFFFC) begin failures++; $display("FAIL wrap_pre_addr got=%h want=fffc", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'hFFFC_0001;
    step();
    imem_ack = 1'b0;
    checks++; if (inst_pc !== 16'hFFFC) begin failures++; $display("FAIL wrap_inst_pc got=%h want=fffc", inst_pc); end
    step();
    checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_addr got=%h want=0000", imem_addr); end
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL pre_illegal_err got=%b want=0", fetch_err); end
    redirect(2'b11, 16'h0040, 16'h0200);
    step();
    redir_valid = 1'b0;
    checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL illegal_addr got=%h want=0000", imem_addr); end
    checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b want=1", fetch_err); end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0ABC;
    step();
    imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL illegal_no_squash got=%b want=1", inst_valid); end
    step();
    checks++; if (imem_addr !== 16'h0004) begin failures++; $display("FAIL illegal_next_addr got=%h want=0004", imem_addr); end
    checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", fetch_err); end
  endtask

  task automatic test_reset_midfetch();
    rst = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rmid_req got=%b want=0", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL rmid_addr got=%h want=0000", imem_addr); end
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL rmid_err got=%b want=0", fetch_err); end
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h5151_5151;
    step();
    imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rmid_stale got=%b want=0", inst_valid); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rmid_restart_req got=%b want=1", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL rmid_restart_addr got=%h want=0000", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h7777_0000;
    step();
    imem_ack = 1'b0;
    checks++; if (inst_data !== 32'h7777_0000) begin failures++; $display("FAIL rmid_data got=%h want=77770000", inst_data); end
  endtask

  task automatic test_misaligned();
    redirect(2'b01, 16'h0000, 16'h0102);
    step();
    redir_valid = 1'b0;
    checks++; if (imem_addr !== 16'h0100) begin failures++; $display("FAIL mis_addr got=%h want=0100", imem_addr); end
    checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL mis_err got=%b want=1", fetch_err); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL mis_valid got=%b want=0", inst_valid); end
  endtask

  task automatic test_redirect_sel();
    redirect(2'b10, 16'h0004, 16'hFFF0);
    step();
    redir_valid = 1'b0;
    checks++; if (imem_addr !== 16'h0100) begin failures++; $display("FAIL rel_hold_addr got=%h want=0100", imem_addr); end
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    checks++; if (imem_addr !== 16'hFFF8) begin failures++; $display("FAIL rel_neg_addr got=%h want=fff8", imem_addr); end
    redirect(2'b00, 16'h0200, 16'h1111);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    redir_valid = 1'b0; imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL seqsel_dropped got=%b want=0", inst_valid); end
    checks++; if (imem_addr !== 16'h0204) begin failures++; $display("FAIL seqsel_addr got=%h want=0204", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h0204_0204;
    step();
    imem_ack = 1'b0;
    checks++; if (inst_pc !== 16'h0204) begin failures++; $display("FAIL seqsel_inst_pc got=%h want=0204", inst_pc); end
    checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL final_err got=%b want=1", fetch_err); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_hold();
    test_boundary();
    test_reset_midfetch();
    test_misaligned();
    test_redirect_sel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
